// File: rtl/mcu_fetch_ctrl.sv
// Purpose: walks the luma capture buffer in 8x8 MCU raster order and packs each MCU into one wide vector.
// Latency: first read 2 cycles after start; mcu_valid 2 cycles after the last read; 66 cycles per MCU when never stalled.
// Backpressure: holds mcu_data/blk_x/blk_y with mcu_valid high until mcu_ready; no reads are issued while stalled.
module mcu_fetch_ctrl #(
  parameter int IMG_W  = 224,
  parameter int IMG_H  = 224,
  parameter int BLK    = 8,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [PIX_W-1:0]           mem_rdata,
  output logic [BLK*BLK*PIX_W-1:0]   mcu_data,
  output logic                       mcu_valid,
  input  logic                       mcu_ready,
  output logic [4:0]                 blk_x,
  output logic [4:0]                 blk_y,
  output logic [9:0]                 blk_count
);

  localparam int NPIX   = BLK * BLK;
  localparam int K_W    = $clog2(NPIX);
  localparam int BLK_LG = $clog2(BLK);

  localparam logic [4:0]     LAST_BX = 5'(IMG_W / BLK - 1);
  localparam logic [4:0]     LAST_BY = 5'(IMG_H / BLK - 1);
  localparam logic [K_W-1:0] LAST_K  = K_W'(NPIX - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]     state;
  logic [K_W-1:0] k;       // next pixel index to issue
  logic [K_W-1:0] rd_k;    // pixel index of the read currently on the bus
  logic [K_W-1:0] cap_k;   // pixel index of the byte arriving on mem_rdata
  logic           cap_vld; // mem_rdata carries a byte this cycle
  logic           last_blk;
  logic [4:0]     nxt_bx;
  logic [4:0]     nxt_by;

  // Buffer address of pixel kk inside MCU (bx,by); row-major, IMG_W pixels per row.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [4:0] bx, input logic [4:0] by,
                                                 input logic [K_W-1:0] kk);
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    row = ADDR_W'(by) * ADDR_W'(BLK) + ADDR_W'(kk >> BLK_LG);
    col = ADDR_W'(bx) * ADDR_W'(BLK) + ADDR_W'(kk & K_W'(BLK - 1));
    return row * ADDR_W'(IMG_W) + col;
  endfunction

  // Raster advance: step right, wrap to column 0 of the next MCU row.
  always_comb begin
    last_blk = (blk_x == LAST_BX) && (blk_y == LAST_BY);
    nxt_bx   = blk_x + 5'd1;
    nxt_by   = blk_y;
    if (blk_x == LAST_BX) begin
      nxt_bx = 5'd0;
      nxt_by = blk_y + 5'd1;
    end
  end

  // Read-return pipeline: the byte for a read lands one cycle later and is dropped into its slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_vld  <= 1'b0;
      cap_k    <= '0;
      mcu_data <= '0;
    end else begin
      cap_vld <= mem_rd_en;
      cap_k   <= rd_k;
      if (cap_vld) begin
        mcu_data[cap_k * PIX_W +: PIX_W] <= mem_rdata;
      end
    end
  end

  // Sequencer: issue 64 reads, wait for the last byte, present, then advance or finish.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      mcu_valid <= 1'b0;
      blk_x     <= '0;
      blk_y     <= '0;
      blk_count <= '0;
      k         <= '0;
      rd_k      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_FETCH;
            busy      <= 1'b1;
            blk_x     <= '0;
            blk_y     <= '0;
            blk_count <= '0;
            k         <= '0;
          end
        end
        S_FETCH: begin
          mem_rd_en <= 1'b1;
          mem_addr  <= pix_addr(blk_x, blk_y, k);
          rd_k      <= k;
          k         <= k + 1'b1;
          if (k == LAST_K) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          mem_rd_en <= 1'b0;
          // The last byte is written on this same edge, so valid and data rise together.
          if (cap_vld && (cap_k == LAST_K)) begin
            state     <= S_PRESENT;
            mcu_valid <= 1'b1;
          end
        end
        S_PRESENT: begin
          if (mcu_ready) begin
            mcu_valid <= 1'b0;
            blk_count <= blk_count + 10'd1;
            if (last_blk) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              // Issue pixel 0 of the next MCU right away so no cycle is lost between MCUs.
              blk_x     <= nxt_bx;
              blk_y     <= nxt_by;
              mem_rd_en <= 1'b1;
              mem_addr  <= pix_addr(nxt_bx, nxt_by, '0);
              rd_k      <= '0;
              k         <= K_W'(1);
              state     <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
